load_ext_ctrl: RTL and testbench
================================

// Module: load_ext_ctrl
// PURPOSE
//  Sequences data-memory loads for the MIPS datapath: accepts a load request from MEM stage,
//  runs a one-outstanding read handshake with data memory, then selects and sign/zero-extends
//  the addressed byte/half/word (LB/LBU/LH/LHU/LW) to 32 bits for writeback.
//  Holds the pipeline (stall) while a load is in flight. Sits between MEM stage and data RAM.
// PARAMETERS
//  ADDR_WIDTH   32  byte-address width of req_addr / mem_addr
//  TIMEOUT_CYC  16  max WAIT cycles before timeout abort (used only with LOAD_EXT_TIMEOUT_EN)
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           synchronous reset, active-high
//  req_valid    in   1           load request present
//  req_ready    out  1           block can accept request (high only in IDLE)
//  req_addr     in   ADDR_WIDTH  byte address of load
//  req_size     in   2           00 byte, 01 half, 10 word, 11 reserved
//  req_sext     in   1           1 = sign-extend, 0 = zero-extend (ignored for word)
//  req_rd       in   5           destination register, returned with response
//  mem_rd_en    out  1           one-cycle read strobe to data memory
//  mem_addr     out  ADDR_WIDTH  word-aligned address (req_addr with [1:0]=0)
//  mem_rdata    in   32          read data, valid when mem_ack=1
//  mem_ack      in   1           memory read complete
//  rsp_valid    out  1           one-cycle response pulse
//  rsp_data     out  32          extended load result
//  rsp_rd       out  5           destination register of response
//  misalign_err out  1           with rsp_valid: access misaligned or size reserved
//  timeout_err  out  1           with rsp_valid: memory ack timeout
//  stall        out  1           pipeline hold, = (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; mem_rd_en=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_rd=0;
//   misalign_err=0; timeout_err=0; stall=0; timeout counter=0. Reset mid-op aborts to IDLE,
//   no response generated; a late mem_ack arriving in IDLE is ignored.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE; error path IDLE -> DONE.
//   IDLE : req_ready=1. On req_valid: latch addr/size/sext/rd. If misaligned (half & addr[0],
//          word & addr[1:0]!=0, or size=11) -> DONE with misalign_err=1, rsp_data=0, no mem access.
//          Else -> ISSUE.
//   ISSUE: mem_rd_en=1 for exactly this cycle, mem_addr={addr[AW-1:2],2'b00} -> WAIT.
//   WAIT : mem_rd_en=0, mem_addr held. On mem_ack: capture extended result -> DONE.
//   DONE : rsp_valid=1 one cycle with rsp_data/rsp_rd/err flags; req_ready=0 -> IDLE.
//  mem_ack in ISSUE cycle is honoured (same as WAIT). Requests are never accepted in DONE.
//  Latency: aligned load with 0-wait memory (ack in cycle after strobe) = req accept at cycle 0,
//   rsp_valid at cycle 3. Error path: rsp_valid at cycle 1.
//  Lane select, little-endian: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
//  Extension: upper bits = req_sext ? lane MSB : 0. Word: rsp_data = mem_rdata unchanged.
//  rsp_data/rsp_rd/err flags hold last value outside DONE; only qualified by rsp_valid.
// CONFIGURATION
//  LOAD_EXT_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle
//   without ack; at TIMEOUT_CYC -> DONE with timeout_err=1, rsp_data=0. Ack on the same cycle
//   as the limit wins (normal response, timeout_err=0).
//  Not defined: WAIT waits indefinitely; counter not built; timeout_err tied 0.
// TESTING
//  LB addr=0x103, sext=1, mem_rdata=0x80FF_1234, ack 1 cycle after strobe -> rsp_data=0xFFFF_FF80,
//   rsp_valid at cycle 3, mem_addr=0x100.
//  LBU addr=0x103, same data -> rsp_data=0x0000_0080; LHU addr=0x102 -> 0x0000_80FF;
//   LH addr=0x100 -> 0x0000_1234.
//  LW addr=0x204, mem_rdata=0xDEAD_BEEF, ack after 5 WAIT cycles -> stall high 7 cycles,
//   rsp_data=0xDEAD_BEEF, rsp_rd matches req_rd.
//  LH addr=0x101 or LW addr=0x102 or size=11 -> no mem_rd_en, rsp_valid next cycle,
//   misalign_err=1, rsp_data=0.
//  rst asserted in WAIT, then mem_ack -> no rsp_valid, req_ready=1 next cycle, next LW completes.
//  LOAD_EXT_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> rsp_valid after 16 WAIT cycles, timeout_err=1;
//   ack on 16th cycle -> normal response, timeout_err=0.

Source files
------------

// File: rtl/load_ext_ctrl.sv
// load_ext_ctrl: load sequencer between the MEM stage and the data RAM.
// It accepts one load request at a time and issues a single read strobe
// with a word-aligned address. The addressed byte, half or word is then
// sign- or zero-extended to 32 bits and returned as a one-cycle response.
// The pipeline is stalled whenever the controller is not idle.
// Optional feature: define LOAD_EXT_TIMEOUT_EN to abort a read that waits
// too long for mem_ack. The response then carries timeout_err. The limit is
// TIMEOUT_CYC cycles spent in WAIT.
module load_ext_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [4:0]            req_rd,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [4:0]            rsp_rd,
    output logic                  misalign_err,
    output logic                  timeout_err,
    output logic                  stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t     state;

    // Request fields latched at acceptance and used for lane select and extension.
    logic [1:0] addr_lo;
    logic [1:0] size_q;
    logic       sext_q;
    logic [4:0] rd_q;

    logic       misaligned;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_data;

`ifdef LOAD_EXT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_limit;
`endif

    // Handshake status is derived directly from the registered state.
    assign req_ready = (state == S_IDLE);
    assign stall     = (state != S_IDLE);

    // Alignment check on the incoming request. Size 11 is reserved and always rejected.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Select the little-endian lane from the returned word and extend it to 32 bits.
    always_comb begin
        lane_b   = 8'h00;
        lane_h   = 16'h0000;
        ext_data = '0;
        case (addr_lo)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: ext_data = {{24{sext_q & lane_b[7]}}, lane_b};
            SZ_HALF: ext_data = {{16{sext_q & lane_h[15]}}, lane_h};
            default: ext_data = mem_rdata;
        endcase
    end

`ifdef LOAD_EXT_TIMEOUT_EN
    // The limit is reached on the TIMEOUT_CYC-th WAIT cycle that passes without an ack.
    assign wait_limit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_err = 1'b0;
`endif

    // Load sequencer: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Misaligned requests go IDLE -> DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_rd       <= '0;
            misalign_err <= 1'b0;
            addr_lo      <= '0;
            size_q       <= '0;
            sext_q       <= 1'b0;
            rd_q         <= '0;
`ifdef LOAD_EXT_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_lo <= req_addr[1:0];
                        size_q  <= req_size;
                        sext_q  <= req_sext;
                        rd_q    <= req_rd;
                        if (misaligned) begin
                            state        <= S_DONE;
                            rsp_valid    <= 1'b1;
                            rsp_data     <= '0;
                            rsp_rd       <= req_rd;
                            misalign_err <= 1'b1;
`ifdef LOAD_EXT_TIMEOUT_EN
                            timeout_err  <= 1'b0;
`endif
                        end else begin
                            state     <= S_ISSUE;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end

                S_ISSUE: begin
                    // An ack in the strobe cycle itself is treated the same as an ack in WAIT.
                    if (mem_ack) begin
                        state        <= S_DONE;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= ext_data;
                        rsp_rd       <= rd_q;
                        misalign_err <= 1'b0;
`ifdef LOAD_EXT_TIMEOUT_EN
                        timeout_err  <= 1'b0;
`endif
                    end else begin
                        state <= S_WAIT;
`ifdef LOAD_EXT_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (mem_ack) begin
                        state        <= S_DONE;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= ext_data;
                        rsp_rd       <= rd_q;
                        misalign_err <= 1'b0;
`ifdef LOAD_EXT_TIMEOUT_EN
                        timeout_err  <= 1'b0;
                    end else if (wait_limit) begin
                        state        <= S_DONE;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_rd       <= rd_q;
                        misalign_err <= 1'b0;
                        timeout_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext_ctrl.sv
// tb_load_ext_ctrl: directed bench for load_ext_ctrl.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// Cycle numbers count from the request-accept cycle, which is cycle 0.
module tb_load_ext_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_sext = 1'b0;
    logic [4:0]  req_rd = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        misalign_err;
    logic        timeout_err;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_ext_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_rd(req_rd),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .misalign_err(misalign_err), .timeout_err(timeout_err), .stall(stall)
    );

    // One complete load.
    // ack_at is the cycle in which mem_ack is high; -1 means the ack is never sent.
    task automatic load_op(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic sext, input logic [4:0] rd, input logic [31:0] rdata,
                           input int ack_at, input logic [31:0] exp_data, input int exp_lat,
                           input logic exp_mis, input logic exp_tmo);
        int  lat = -1;
        int  stall_cnt = 0;
        int  rden_cnt = 0;
        bit  got = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_sext = sext; req_rd = rd;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s.ready: got %b expected 1", name, req_ready); end
        for (int c = 1; c <= 64 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : 32'h5A5A_A5A5;
            if (stall === 1'b1) stall_cnt++;
            if (mem_rd_en === 1'b1) begin
                rden_cnt++;
                n_checks++;
                if (mem_addr !== {addr[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL %s.mem_addr: got %h expected %h", name, mem_addr, {addr[31:2], 2'b00});
                end
            end
            if (rsp_valid === 1'b1) begin got = 1; lat = c; end
        end
        mem_ack = 1'b0;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL %s.no_rsp: got none expected rsp_valid", name); end
        n_checks++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s.latency: got %0d expected %0d", name, lat, exp_lat); end
        n_checks++;
        if (rsp_data !== exp_data) begin n_fail++; $display("FAIL %s.rsp_data: got %h expected %h", name, rsp_data, exp_data); end
        n_checks++;
        if (rsp_rd !== rd) begin n_fail++; $display("FAIL %s.rsp_rd: got %0d expected %0d", name, rsp_rd, rd); end
        n_checks++;
        if (misalign_err !== exp_mis) begin n_fail++; $display("FAIL %s.misalign_err: got %b expected %b", name, misalign_err, exp_mis); end
        n_checks++;
        if (timeout_err !== exp_tmo) begin n_fail++; $display("FAIL %s.timeout_err: got %b expected %b", name, timeout_err, exp_tmo); end
        n_checks++;
        if (rden_cnt != (exp_mis ? 0 : 1)) begin n_fail++; $display("FAIL %s.rd_en_count: got %0d expected %0d", name, rden_cnt, exp_mis ? 0 : 1); end
        n_checks++;
        if (stall_cnt != exp_lat) begin n_fail++; $display("FAIL %s.stall_cycles: got %0d expected %0d", name, stall_cnt, exp_lat); end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready, stall} !== 3'b010) begin
            n_fail++; $display("FAIL %s.after: got valid/ready/stall=%b expected 010", name, {rsp_valid, req_ready, stall});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, mem_rd_en, rsp_valid, misalign_err, timeout_err, stall} !== 6'b100000) begin
            n_fail++; $display("FAIL reset.flags: got %b expected 100000", {req_ready, mem_rd_en, rsp_valid, misalign_err, timeout_err, stall});
        end
        n_checks++;
        if ({mem_addr, rsp_data, rsp_rd} !== 69'd0) begin
            n_fail++; $display("FAIL reset.values: got addr=%h data=%h rd=%0d expected all 0", mem_addr, rsp_data, rsp_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_lane_extend();
        load_op("lb_sext",  32'h103, 2'b00, 1'b1, 5'd3,  32'h80FF_1234, 2, 32'hFFFF_FF80, 3, 1'b0, 1'b0);
        load_op("lbu",      32'h103, 2'b00, 1'b0, 5'd4,  32'h80FF_1234, 2, 32'h0000_0080, 3, 1'b0, 1'b0);
        load_op("lhu",      32'h102, 2'b01, 1'b0, 5'd5,  32'h80FF_1234, 2, 32'h0000_80FF, 3, 1'b0, 1'b0);
        load_op("lh_lo",    32'h100, 2'b01, 1'b1, 5'd6,  32'h80FF_1234, 2, 32'h0000_1234, 3, 1'b0, 1'b0);
        load_op("lh_hi",    32'h102, 2'b01, 1'b1, 5'd7,  32'h80FF_1234, 2, 32'hFFFF_80FF, 3, 1'b0, 1'b0);
        load_op("lb_b1",    32'h101, 2'b00, 1'b1, 5'd8,  32'h80FF_1234, 2, 32'h0000_0012, 3, 1'b0, 1'b0);
        load_op("lw_sext",  32'h010, 2'b10, 1'b0, 5'd9,  32'h8765_4321, 2, 32'h8765_4321, 3, 1'b0, 1'b0);
    endtask

    task automatic test_wait_states();
        load_op("lw_wait5", 32'h204, 2'b10, 1'b0, 5'd17, 32'hDEAD_BEEF, 6, 32'hDEAD_BEEF, 7, 1'b0, 1'b0);
        load_op("ack_issue", 32'h300, 2'b00, 1'b1, 5'd18, 32'h0000_00F0, 1, 32'hFFFF_FFF0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_misalign();
        load_op("lh_mis",   32'h101, 2'b01, 1'b1, 5'd10, 32'hFFFF_FFFF, -1, 32'h0, 1, 1'b1, 1'b0);
        load_op("lw_mis",   32'h102, 2'b10, 1'b0, 5'd11, 32'hFFFF_FFFF, -1, 32'h0, 1, 1'b1, 1'b0);
        load_op("size_rsv", 32'h100, 2'b11, 1'b0, 5'd12, 32'hFFFF_FFFF, -1, 32'h0, 1, 1'b1, 1'b0);
        load_op("after_mis", 32'h104, 2'b10, 1'b0, 5'd13, 32'h1357_9BDF, 2, 32'h1357_9BDF, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h400; req_size = 2'b10; req_sext = 1'b0; req_rd = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        n_checks++;
        if ({rsp_valid, req_ready, stall} !== 3'b010) begin
            n_fail++; $display("FAIL rst_mid.idle: got valid/ready/stall=%b expected 010", {rsp_valid, req_ready, stall});
        end
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if ({rsp_valid, req_ready, stall, mem_rd_en} !== 4'b0100) begin
            n_fail++; $display("FAIL rst_mid.late_ack: got valid/ready/stall/rd_en=%b expected 0100", {rsp_valid, req_ready, stall, mem_rd_en});
        end
        load_op("rst_next_lw", 32'h408, 2'b10, 1'b0, 5'd21, 32'h0BAD_CAFE, 2, 32'h0BAD_CAFE, 3, 1'b0, 1'b0);
    endtask

    task automatic test_long_wait();
`ifdef LOAD_EXT_TIMEOUT_EN
        load_op("timeout",   32'h500, 2'b10, 1'b0, 5'd22, 32'h1111_2222, -1, 32'h0, 18, 1'b0, 1'b1);
        load_op("ack_limit", 32'h504, 2'b10, 1'b0, 5'd23, 32'h3333_4444, 17, 32'h3333_4444, 18, 1'b0, 1'b0);
`else
        load_op("long_wait", 32'h500, 2'b10, 1'b0, 5'd22, 32'h1111_2222, 22, 32'h1111_2222, 23, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_lane_extend();
        test_wait_states();
        test_misalign();
        test_reset_mid_op();
        test_long_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
